// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, buffers {pc, instr} pairs in a FIFO toward Decode,
// handles redirects with a one-cycle flush pulse and emits a delayed PC-history stream.
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2,
  parameter int HIST_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic                   o_dec_valid,
  input  logic                   i_dec_ready,
  output logic [ADDR_WIDTH-1:0]  o_dec_pc,
  output logic [INSTR_WIDTH-1:0] o_dec_instr,
  input  logic                   i_redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_flush,
  output logic                   o_wb_pc_valid,
  output logic [ADDR_WIDTH-1:0]  o_wb_pc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_fpc [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] r_finstr [FIFO_DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic                   r_flush;
  logic                   r_hv [HIST_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_hpc [HIST_DEPTH];
  logic                   w_fire;
  logic                   w_push;
  assign o_imem_addr   = r_pc;
  assign o_dec_valid   = (r_count != '0);
  assign o_dec_pc      = r_fpc[r_rptr];
  assign o_dec_instr   = r_finstr[r_rptr];
  assign o_flush       = r_flush;
  assign o_wb_pc_valid = r_hv[HIST_DEPTH-1];
  assign o_wb_pc       = r_hpc[HIST_DEPTH-1];
  assign w_fire = o_dec_valid & i_dec_ready & ~i_redirect_valid;
  // a full buffer may still accept a push when its head leaves in the same cycle
  assign w_push = ~i_redirect_valid & ((r_count < CW'(FIFO_DEPTH)) | w_fire);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_flush <= 1'b0;
    end else if (i_redirect_valid) begin
      r_pc    <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_flush <= 1'b1;
    end else begin
      r_flush <= 1'b0;
      r_pc    <= w_push ? r_pc + ADDR_WIDTH'(4) : r_pc;
      r_wptr  <= w_push ? r_wptr + PW'(1) : r_wptr;
      r_rptr  <= w_fire ? r_rptr + PW'(1) : r_rptr;
      r_count <= r_count + CW'(w_push) - CW'(w_fire);
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fpc[r_wptr]    <= r_pc;
      r_finstr[r_wptr] <= i_imem_rdata;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_hv[i]  <= 1'b0;
        r_hpc[i] <= '0;
      end
    end else begin
      r_hv[0]  <= w_fire;
      r_hpc[0] <= o_dec_pc;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        r_hv[i]  <= r_hv[i-1];
        r_hpc[i] <= r_hpc[i-1];
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch sequencing, stalls, redirects, history and reset.
module tb_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        wb_pc_valid;
  logic [31:0] wb_pc;
  int          n_checks;
  int          n_fail;
  localparam logic [31:0] KEY = 32'hDEAD_0000;
  fetch_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .o_dec_valid(dec_valid), .i_dec_ready(dec_ready), .o_dec_pc(dec_pc), .o_dec_instr(dec_instr),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc), .o_flush(flush),
    .o_wb_pc_valid(wb_pc_valid), .o_wb_pc(wb_pc)
  );
  assign imem_rdata = imem_addr ^ KEY;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic chk_head(input string name, input logic [31:0] pc);
    n_checks++;
    if (dec_valid !== 1'b1 || dec_pc !== pc || dec_instr !== (pc ^ KEY)) begin
      n_fail++;
      $display("FAIL %s: got valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
               name, dec_valid, dec_pc, dec_instr, pc, pc ^ KEY);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dec_valid !== 1'b0 || flush !== 1'b0 || wb_pc_valid !== 1'b0 || wb_pc !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b flush=%b wbv=%b wb_pc=%h addr=%h, required 0 0 0 0 0",
               dec_valid, flush, wb_pc_valid, wb_pc, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_head("stream_after_reset", 32'(k * 4));
    end
  endtask
  task automatic test_stall;
    do_reset(1'b0);
    repeat (6) @(negedge clk);
    n_checks++;
    if (imem_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL stall_addr_hold: got %h, required 00000008", imem_addr);
    end
    chk_head("stall_head", 32'h0);
    dec_ready = 1'b1;
    @(negedge clk);
    chk_head("release_1", 32'h4);
    @(negedge clk);
    chk_head("release_2", 32'h8);
    @(negedge clk);
    chk_head("release_3", 32'hC);
  endtask
  task automatic test_redirect_full;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    n_checks++;
    if (dec_valid !== 1'b0 || flush !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_flush: got valid=%b flush=%b addr=%h, required 0 1 00000100",
               dec_valid, flush, imem_addr);
    end
    @(negedge clk);
    chk_head("redirect_target", 32'h100);
    n_checks++;
    if (flush !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_one_cycle: got %b, required 0", flush);
    end
  endtask
  task automatic test_redirect_align_wrap;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_addr !== 32'h100 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_redirect: got addr=%h valid=%b, required 00000100 0", imem_addr, dec_valid);
    end
    @(negedge clk);
    chk_head("misaligned_head", 32'h100);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL top_redirect_addr: got %h, required fffffffc", imem_addr);
    end
    @(negedge clk);
    chk_head("wrap_top", 32'hFFFF_FFFC);
    @(negedge clk);
    chk_head("wrap_zero", 32'h0);
  endtask
  task automatic test_back_to_back;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_pc = 32'h300;
    n_checks++;
    if (flush !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL b2b_first: got flush=%b addr=%h, required 1 00000200", flush, imem_addr);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (flush !== 1'b1 || imem_addr !== 32'h300 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got flush=%b addr=%h valid=%b, required 1 00000300 0", flush, imem_addr, dec_valid);
    end
    @(negedge clk);
    chk_head("b2b_target", 32'h300);
    n_checks++;
    if (flush !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_flush_drop: got %b, required 0", flush);
    end
  endtask
  task automatic test_history;
    logic       exp_v  [1:10];
    logic [31:0] exp_pc [1:10];
    exp_v  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_pc = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC};
    do_reset(1'b1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      dec_ready = !(n == 4 || n == 5);
      n_checks++;
      if (wb_pc_valid !== exp_v[n] || (exp_v[n] && wb_pc !== exp_pc[n])) begin
        n_fail++;
        $display("FAIL history_slot_%0d: got valid=%b pc=%h, required valid=%b pc=%h",
                 n, wb_pc_valid, wb_pc, exp_v[n], exp_pc[n]);
      end
    end
  endtask
  task automatic test_async_reset;
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (wb_pc_valid !== 1'b1 || dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_active: got wbv=%b valid=%b, required 1 1", wb_pc_valid, dec_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dec_valid !== 1'b0 || flush !== 1'b0 || wb_pc_valid !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b flush=%b wbv=%b addr=%h, required 0 0 0 00000000",
               dec_valid, flush, wb_pc_valid, imem_addr);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_head("restart_0", 32'h0);
    @(negedge clk);
    chk_head("restart_4", 32'h4);
  endtask
  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset;
    test_stall;
    test_redirect_full;
    test_redirect_align_wrap;
    test_back_to_back;
    test_history;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
